// File: rtl/sim_oserdes_mc_pkg.sv
// Shared types and helpers for the multi-channel behavioural output serializer.
`timescale 1ps/1ps
package sim_oserdes_mc_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SYNC0 = 2'd1,
    ST_SYNC1 = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // PRBS7: x^7 + x^6 + 1, Fibonacci form shifting left.
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // clk_in rising edges spanned by one parallel word.
  function automatic int unsigned word_cycles(input int unsigned ratio, input int unsigned ddr);
    return (ddr != 0) ? ratio / 2 : ratio;
  endfunction

  function automatic logic [6:0] prbs7_seed(input int unsigned lane);
    logic [6:0] s;
    s = PRBS7_SEED;
    for (int unsigned i = 0; i < lane % 7; i++) s = {s[5:0], s[6]};
    return s;
  endfunction

endpackage

// File: rtl/sim_oserdes_lane.sv
// One serial lane: word shift register, SDR/DDR bit launch and differential pin drive.
`timescale 1ps/1ps
module sim_oserdes_lane
  import sim_oserdes_mc_pkg::*;
#(
  parameter int unsigned RATIO     = 8,
  parameter int unsigned DDR       = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk_in,
  input  logic             io_reset,
  input  logic             i_load,
  input  logic             i_live,
  input  logic [RATIO-1:0] i_word,
  output logic             o_p,
  output logic             o_n
);

  logic [RATIO-1:0] w_word;
  logic [RATIO-1:0] r_sh;
  logic             r_bit_p;
  logic             w_bit;

  always_comb begin
    w_word = '0;
    for (int unsigned b = 0; b < RATIO; b++)
      w_word[b] = (MSB_FIRST != 0) ? i_word[RATIO-1-b] : i_word[b];
  end

  // r_sh holds the not-yet-launched bits; DDR consumes two per rising edge.
  always_ff @(posedge clk_in or posedge io_reset) begin
    if (io_reset) begin
      r_sh    <= '0;
      r_bit_p <= 1'b0;
    end else if (i_load) begin
      r_bit_p <= w_word[0];
      r_sh    <= w_word >> 1;
    end else if (DDR != 0) begin
      r_bit_p <= r_sh[1];
      r_sh    <= r_sh >> 2;
    end else begin
      r_bit_p <= r_sh[0];
      r_sh    <= r_sh >> 1;
    end
  end

  if (DDR != 0) begin : g_ddr
    logic r_bit_n;
    always_ff @(negedge clk_in or posedge io_reset) begin
      if (io_reset) r_bit_n <= 1'b0;
      else          r_bit_n <= r_sh[0];
    end
    assign w_bit = clk_in ? r_bit_p : r_bit_n;
  end else begin : g_sdr
    assign w_bit = r_bit_p;
  end

  assign o_p = i_live & w_bit;
  assign o_n = ~o_p;

endmodule

// File: rtl/sim_oserdes_mc.sv
// Multi-channel behavioural output serializer: sync FSM, word capture, word counter, fast counter.
// Optional per-lane PRBS7 training source enabled by SIM_OSERDES_MC_PRBS_EN.
`timescale 1ps/1ps
module sim_oserdes_mc
  import sim_oserdes_mc_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned RATIO      = 8,
  parameter int unsigned DDR        = 1,
  parameter int unsigned MSB_FIRST  = 0,
  parameter logic [15:0] IDLE_WORD  = 16'h0000,
  parameter logic [15:0] TRAIN_WORD = 16'h0035
) (
  input  logic                      clk_div_in,
  input  logic                      io_reset,
  input  logic                      clk_in,
  input  logic [CHANNELS*RATIO-1:0] data_out_from_device,
  input  logic                      data_valid,
  input  logic                      train_en,
  output logic                      ready,
  output logic [CHANNELS-1:0]       data_out_to_pins_p,
  output logic [CHANNELS-1:0]       data_out_to_pins_n,
  output logic [15:0]               words_sent
);

  localparam logic [RATIO-1:0] IDLE_W   = IDLE_WORD[RATIO-1:0];
  localparam logic [RATIO-1:0] TRAIN_W  = TRAIN_WORD[RATIO-1:0];
  localparam int unsigned      WCYC     = word_cycles(RATIO, DDR);
  localparam int unsigned      CW       = (WCYC > 1) ? $clog2(WCYC) : 1;
  localparam logic [CW-1:0]    HOLD_CNT = (WCYC > 1) ? CW'(1) : CW'(0);

  state_t        r_state, w_state_nxt;
  logic          w_capture;
  logic          r_ready;
  logic [15:0]   r_words;
  logic [CW-1:0] r_cnt;
  logic          r_live;
  logic          w_load;

  always_ff @(posedge clk_div_in or posedge io_reset) begin
    if (io_reset) r_state <= ST_RESET;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_RESET: w_state_nxt = ST_SYNC0;
      ST_SYNC0: w_state_nxt = ST_SYNC1;
      ST_SYNC1: begin
        w_state_nxt = ST_RUN;
        w_capture   = 1'b1;
      end
      default:  w_capture = 1'b1;
    endcase
  end

  always_ff @(posedge clk_div_in or posedge io_reset) begin
    if (io_reset) begin
      r_ready <= 1'b0;
      r_words <= '0;
    end else begin
      r_ready <= (w_state_nxt == ST_RUN);
      if (w_capture && !train_en && data_valid) r_words <= r_words + 16'd1;
    end
  end

  // Held at slot 1 while in RESET: the clk_in rise that coincides with the edge
  // leaving RESET is slot 0, so later wraps land on clk_div_in rising edges.
  always_ff @(posedge clk_in or posedge io_reset) begin
    if (io_reset) begin
      r_cnt  <= '0;
      r_live <= 1'b0;
    end else begin
      if (r_state == ST_RESET)         r_cnt <= HOLD_CNT;
      else if (r_cnt == CW'(WCYC - 1)) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);
      if (w_load) r_live <= r_ready;
    end
  end

  assign w_load = (r_cnt == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [RATIO-1:0] w_train;
    logic [RATIO-1:0] r_cap;

`ifdef SIM_OSERDES_MC_PRBS_EN
    logic [6:0]       r_prbs;
    logic [6:0]       w_prbs_nxt;
    logic [RATIO-1:0] w_prbs_word;

    always_comb begin
      w_prbs_nxt  = r_prbs;
      w_prbs_word = '0;
      for (int unsigned b = 0; b < RATIO; b++) begin
        w_prbs_word[b] = ^(w_prbs_nxt & PRBS7_TAPS);
        w_prbs_nxt     = {w_prbs_nxt[5:0], w_prbs_word[b]};
      end
    end

    always_ff @(posedge clk_div_in or posedge io_reset) begin
      if (io_reset)       r_prbs <= prbs7_seed(c);
      else if (w_capture) r_prbs <= w_prbs_nxt;
    end

    assign w_train = w_prbs_word;
`else
    assign w_train = TRAIN_W;
`endif

    always_ff @(posedge clk_div_in or posedge io_reset) begin
      if (io_reset) r_cap <= IDLE_W;
      else if (w_capture) begin
        if (train_en)        r_cap <= w_train;
        else if (data_valid) r_cap <= data_out_from_device[c*RATIO +: RATIO];
        else                 r_cap <= IDLE_W;
      end
    end

    sim_oserdes_lane #(
      .RATIO     (RATIO),
      .DDR       (DDR),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk_in   (clk_in),
      .io_reset (io_reset),
      .i_load   (w_load),
      .i_live   (r_live),
      .i_word   (r_cap),
      .o_p      (data_out_to_pins_p[c]),
      .o_n      (data_out_to_pins_n[c])
    );
  end

  assign ready      = r_ready;
  assign words_sent = r_words;

endmodule

// File: tb/tb_sim_oserdes_mc.sv
// Directed bench for sim_oserdes_mc: DDR 2-lane 8:1 instance plus SDR 1-lane 4:1 instance.
`timescale 1ps/1ps
module tb_sim_oserdes_mc;

  logic clk_div_in = 1'b0;
  logic clk_in     = 1'b1;
  logic io_reset   = 1'b1;

  always #8000 clk_div_in = ~clk_div_in;
  always #2000 clk_in     = ~clk_in;

  logic [15:0] din   = '0;
  logic        valid = 1'b0;
  logic        train = 1'b0;
  logic        ready;
  logic [1:0]  p, n;
  logic [15:0] ws;

  logic [3:0]  din_s   = '0;
  logic        valid_s = 1'b0;
  logic        train_s = 1'b0;
  logic        ready_s;
  logic [0:0]  p_s, n_s;
  logic [15:0] ws_s;

  sim_oserdes_mc #(
    .CHANNELS(2), .RATIO(8), .DDR(1), .MSB_FIRST(0), .IDLE_WORD(16'h0000), .TRAIN_WORD(16'h0035)
  ) u_dut (
    .clk_div_in           (clk_div_in),
    .io_reset             (io_reset),
    .clk_in               (clk_in),
    .data_out_from_device (din),
    .data_valid           (valid),
    .train_en             (train),
    .ready                (ready),
    .data_out_to_pins_p   (p),
    .data_out_to_pins_n   (n),
    .words_sent           (ws)
  );

  sim_oserdes_mc #(
    .CHANNELS(1), .RATIO(4), .DDR(0), .MSB_FIRST(0), .IDLE_WORD(16'h0000), .TRAIN_WORD(16'h0035)
  ) u_sdr (
    .clk_div_in           (clk_div_in),
    .io_reset             (io_reset),
    .clk_in               (clk_in),
    .data_out_from_device (din_s),
    .data_valid           (valid_s),
    .train_en             (train_s),
    .ready                (ready_s),
    .data_out_to_pins_p   (p_s),
    .data_out_to_pins_n   (n_s),
    .words_sent           (ws_s)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin decoder: samples mid-bit for every slow cycle, indexed by slow edge count.
  int unsigned cyc     = 0;
  int unsigned n_err   = 0;
  int unsigned sdr_err = 0;
  logic [7:0]  dec0 [512];
  logic [7:0]  dec1 [512];
  logic [3:0]  decs [512];

  always @(posedge clk_div_in) begin : mon
    logic [7:0]  a0, a1;
    logic [3:0]  s;
    logic        s_even;
    int unsigned idx;
    cyc = cyc + 1;
    idx = cyc % 512;
    a0 = '0; a1 = '0; s = '0; s_even = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #(j == 0 ? 1000 : 2000);
      a0[j] = p[0];
      a1[j] = p[1];
      if (n !== ~p) n_err++;
      if (n_s !== ~p_s) n_err++;
      if (j % 2 == 0) s_even = p_s[0];
      else begin
        s[j/2] = p_s[0];
        if (p_s[0] !== s_even && !io_reset) sdr_err++;
      end
    end
    dec0[idx] = a0;
    dec1[idx] = a1;
    decs[idx] = s;
  end

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        train;
    logic [3:0]  sdata;
    logic        svalid;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [3:0]  es;
    logic [15:0] ews;
  } vec_t;

  localparam int NV = 28;
  vec_t        vt   [NV];
  int unsigned capi [NV];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned cap;

    vt[0] = '{16'hF00F, 1'b1, 1'b0, 4'b1001, 1'b1, 8'h0F, 8'hF0, 4'b1001, 16'd1};
    for (int i = 0; i < 20; i++)
      vt[1+i] = '{{8'h5A, 8'(15*i)}, 1'b1, 1'b0, (i == 0) ? 4'b0011 : 4'hF, (i == 0),
                  8'(15*i), 8'h5A, (i == 0) ? 4'b0011 : 4'h0, 16'(2+i)};
    for (int i = 21; i < 24; i++)
      vt[i] = '{16'hBEEF, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00, 8'h00, 4'h0, 16'd21};
    vt[24] = '{16'h1234, 1'b1, 1'b1, 4'hF, 1'b0, 8'h35, 8'h35, 4'h0, 16'd21};
    vt[25] = '{16'h1234, 1'b1, 1'b1, 4'hF, 1'b0, 8'h35, 8'h35, 4'h0, 16'd21};
    vt[26] = '{16'h5555, 1'b0, 1'b1, 4'hF, 1'b0, 8'h35, 8'h35, 4'h0, 16'd21};
    vt[27] = '{16'h3C81, 1'b1, 1'b0, 4'hF, 1'b0, 8'h81, 8'h3C, 4'h0, 16'd22};

    // Reset held across two slow cycles.
    #20000;
    chk("rst_p", 32'(p), 32'h0);
    chk("rst_n", 32'(n), 32'h3);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_words", 32'(ws), 32'h0);
    chk("rst_sdr_n", 32'(n_s), 32'h1);
    @(negedge clk_div_in);
    io_reset = 1'b0;
    repeat (2) begin
      @(posedge clk_div_in); #1;
      chk("sync_ready", 32'(ready), 32'h0);
      chk("sync_p", 32'(p), 32'h0);
    end
    @(posedge clk_div_in); #1;
    chk("ready_rise", 32'(ready), 32'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_div_in);
      din     = vt[i].data;
      valid   = vt[i].valid;
      train   = vt[i].train;
      din_s   = vt[i].sdata;
      valid_s = vt[i].svalid;
      @(posedge clk_div_in); #1;
      capi[i] = cyc;
      chk("words_sent", 32'(ws), 32'(vt[i].ews));
    end
    @(negedge clk_div_in);
    valid = 1'b0; train = 1'b0; valid_s = 1'b0;
    repeat (2) @(posedge clk_div_in);
    #1;
    for (int i = 0; i < NV; i++) begin
      chk("lane0_word", 32'(dec0[(capi[i] + 1) % 512]), 32'(vt[i].e0));
      chk("lane1_word", 32'(dec1[(capi[i] + 1) % 512]), 32'(vt[i].e1));
      chk("sdr_word",   32'(decs[(capi[i] + 1) % 512]), 32'(vt[i].es));
    end
    chk("sdr_words_sent", 32'(ws_s), 32'd2);

    // Reset asserted during bit 3 of an in-flight word.
    @(negedge clk_div_in);
    din = 16'h0FFF; valid = 1'b1;
    @(posedge clk_div_in); #1;
    chk("pre_rst_words", 32'(ws), 32'd23);
    @(negedge clk_div_in);
    valid = 1'b0;
    @(posedge clk_div_in);
    #6400;
    chk("bit3_p", 32'(p), 32'h3);
    #100;
    io_reset = 1'b1;
    #1;
    chk("midrst_p", 32'(p), 32'h0);
    chk("midrst_n", 32'(n), 32'h3);
    chk("midrst_ready", 32'(ready), 32'h0);
    chk("midrst_words", 32'(ws), 32'h0);
    @(negedge clk_div_in);
    io_reset = 1'b0;
    repeat (2) begin
      @(posedge clk_div_in); #1;
      chk("resync_ready", 32'(ready), 32'h0);
      chk("resync_p", 32'(p), 32'h0);
    end
    @(posedge clk_div_in); #1;
    chk("resync_ready_rise", 32'(ready), 32'h1);
    @(negedge clk_div_in);
    din = 16'h96C3; valid = 1'b1;
    @(posedge clk_div_in); #1;
    cap = cyc;
    chk("resync_words", 32'(ws), 32'd1);
    @(negedge clk_div_in);
    valid = 1'b0;
    #7999;
    chk("pre_launch_p", 32'(p), 32'h0);
    #2;
    chk("first_bit_p", 32'(p), 32'h1);
    @(posedge clk_div_in); #1;
    chk("resync_lane0", 32'(dec0[(cap + 1) % 512]), 32'hC3);
    chk("resync_lane1", 32'(dec1[(cap + 1) % 512]), 32'h96);

    chk("pn_complement_errors", n_err, 32'd0);
    chk("sdr_rise_only_errors", sdr_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
